univ_shift_reg: RTL and testbench



---
 rtl/shreg_pkg.sv | 32 +++
 rtl/word_counter.sv | 55 +++++
 rtl/univ_shift_reg.sv | 95 +++++++++
 tb/tb_univ_shift_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the counter-width helper used to size shift_cnt.
package shreg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   // Ceiling log2; clog2(1) is 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Width of a modulo-n counter, never less than one bit.
   function automatic int cnt_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/word_counter.sv
// Modulo-WIDTH shift counter. Emits a one-cycle registered pulse on the
// increment that wraps the count back to zero. clr restarts the count
// without a pulse; reset has priority over clr, clr over inc.
module word_counter
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      inc,
   output logic [cnt_w(WIDTH)-1:0]   cnt,
   output logic                      wrap_pulse
);

   localparam int CW = cnt_w(WIDTH);
   // Explicit compare so non-power-of-two widths wrap at WIDTH-1.
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap_q, wrap_d;

   // Next count and pulse; the pulse defaults low so any non-wrapping edge clears it.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   // Counter and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt        = cnt_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, logical shifts, rotates, arithmetic
// shift right and clear, with a shared shift counter that pulses word_done
// on every WIDTH-th counted shift.
module univ_shift_reg
   import shreg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [2:0]                mode,
   input  logic [WIDTH-1:0]          d,
   input  logic                      sin_msb,
   input  logic                      sin_lsb,
   output logic [WIDTH-1:0]          q,
   output logic                      sout_msb,
   output logic                      sout_lsb,
   output logic [cnt_w(WIDTH)-1:0]   shift_cnt,
   output logic                      word_done
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             cnt_clr;
   logic             cnt_inc;

   // Mode mux: next register value plus counter restart/advance requests.
   // en=0 leaves everything idle, which also forces word_done low next edge.
   always_comb begin
      q_d     = q_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (en) begin
         case (mode)
            MODE_LOAD: begin
               q_d     = d;
               cnt_clr = 1'b1;
            end
            MODE_SHL: begin
               q_d     = {q_q[WIDTH-2:0], sin_lsb};
               cnt_inc = 1'b1;
            end
            MODE_SHR: begin
               q_d     = {sin_msb, q_q[WIDTH-1:1]};
               cnt_inc = 1'b1;
            end
            MODE_ROL: begin
               q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               cnt_inc = 1'b1;
            end
            MODE_ROR: begin
               q_d     = {q_q[0], q_q[WIDTH-1:1]};
               cnt_inc = 1'b1;
            end
            MODE_ASR: begin
               q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
               cnt_inc = 1'b1;
            end
            MODE_CLR: begin
               q_d     = RESET_VAL;
               cnt_clr = 1'b1;
            end
            default: begin
               q_d = q_q;
            end
         endcase
      end
   end

   // Data register with synchronous reset to RESET_VAL.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   word_counter #(
      .WIDTH (WIDTH)
   ) u_word_counter (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .cnt        (shift_cnt),
      .wrap_pulse (word_done)
   );

   assign q        = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit and a 5-bit (RESET_VAL=5'h15) instance
// share all stimulus. A word-level model tracks both and is compared every
// cycle; directed steps add hand-computed literal expectations.
module tb_univ_shift_reg;
   import shreg_pkg::*;

   logic       clk;
   logic       reset;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_msb;
   logic       sin_lsb;

   logic [7:0] q8;
   logic       smsb8, slsb8, wd8;
   logic [2:0] cnt8;
   logic [4:0] q5;
   logic       smsb5, slsb5, wd5;
   logic [2:0] cnt5;

   int tests;
   int fails;
   bit chk_on;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q8), .sout_msb(smsb8),
      .sout_lsb(slsb8), .shift_cnt(cnt8), .word_done(wd8)
   );

   univ_shift_reg #(.WIDTH(5), .RESET_VAL(5'h15)) dut5 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d[4:0]),
      .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q5), .sout_msb(smsb5),
      .sout_lsb(slsb5), .shift_cnt(cnt5), .word_done(wd5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int     mw[2]  = '{8, 5};
   longint mrv[2] = '{64'h00, 64'h15};
   longint mq[2];
   int     mshifts[2];
   int     mwd[2];

   function automatic longint mask_of(int w);
      return (64'd1 << w) - 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         longint m;
         longint top;
         bit     counted;
         m       = mask_of(mw[i]);
         top     = (mq[i] >> (mw[i] - 1)) & 1;
         counted = 1'b0;
         mwd[i]  = 0;
         if (reset) begin
            mq[i]      = mrv[i];
            mshifts[i] = 0;
         end else if (en) begin
            case (mode)
               3'd1: begin mq[i] = longint'(d) & m; mshifts[i] = 0; end
               3'd2: begin mq[i] = ((mq[i] << 1) | longint'(sin_lsb)) & m; counted = 1; end
               3'd3: begin mq[i] = (mq[i] >> 1) | (longint'(sin_msb) << (mw[i] - 1)); counted = 1; end
               3'd4: begin mq[i] = ((mq[i] << 1) | top) & m; counted = 1; end
               3'd5: begin mq[i] = (mq[i] >> 1) | ((mq[i] & 1) << (mw[i] - 1)); counted = 1; end
               3'd6: begin mq[i] = (mq[i] >> 1) | (top << (mw[i] - 1)); counted = 1; end
               3'd7: begin mq[i] = mrv[i]; mshifts[i] = 0; end
               default: ;
            endcase
            if (counted) begin
               mshifts[i] = mshifts[i] + 1;
               if (mshifts[i] == mw[i]) begin
                  mshifts[i] = 0;
                  mwd[i]     = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("m8.q",    longint'(q8),    mq[0]);
         chk("m8.smsb", longint'(smsb8), (mq[0] >> 7) & 1);
         chk("m8.slsb", longint'(slsb8), mq[0] & 1);
         chk("m8.cnt",  longint'(cnt8),  longint'(mshifts[0]));
         chk("m8.wd",   longint'(wd8),   longint'(mwd[0]));
         chk("m5.q",    longint'(q5),    mq[1]);
         chk("m5.smsb", longint'(smsb5), (mq[1] >> 4) & 1);
         chk("m5.slsb", longint'(slsb5), mq[1] & 1);
         chk("m5.cnt",  longint'(cnt5),  longint'(mshifts[1]));
         chk("m5.wd",   longint'(wd5),   longint'(mwd[1]));
      end
   end

   // One clock edge with the given inputs; returns at the following negedge.
   task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sm);
      en      = e;
      mode    = m;
      d       = dd;
      sin_lsb = sl;
      sin_msb = sm;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [2:0] tmodes[7]  = '{MODE_ROL, MODE_ROR, MODE_ASR, MODE_SHR, MODE_SHL, MODE_CLR, MODE_HOLD};
   logic [7:0] texp[7]    = '{8'h03, 8'hC0, 8'hC0, 8'h40, 8'h03, 8'h00, 8'h81};
   logic [7:0] tcnt[7]    = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};
   logic       serial[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [4:0] rol5[10]   = '{5'h0B, 5'h16, 5'h0D, 5'h1A, 5'h15, 5'h0B, 5'h16, 5'h0D, 5'h1A, 5'h15};

   initial begin
      tests   = 0;
      fails   = 0;
      chk_on  = 1'b0;
      mq      = '{0, 0};
      mshifts = '{0, 0};
      mwd     = '{0, 0};

      // 1. reset wins over en/LOAD
      reset = 1'b1;
      cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
      chk_on = 1'b1;
      chk("rst.q8",  longint'(q8),   64'h00);
      chk("rst.cnt", longint'(cnt8), 0);
      chk("rst.wd",  longint'(wd8),  0);
      chk("rst.q5",  longint'(q5),   64'h15);
      reset = 1'b0;
      cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
      chk("load.ff", longint'(q8), 64'hFF);
      chk("load.q5", longint'(q5), 64'h1F);

      // 2. mode table from 8'h81
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
         cyc(1'b1, tmodes[i], 8'h00, 1'b1, 1'b0);
         chk($sformatf("mode%0d.q", i),   longint'(q8),   longint'(texp[i]));
         chk($sformatf("mode%0d.cnt", i), longint'(cnt8), longint'(tcnt[i]));
      end

      // 3. serialisation of 8'hA5
      cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ser.sout%0d", i), longint'(smsb8), longint'(serial[i]));
         cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
         chk($sformatf("ser.cnt%0d", i), longint'(cnt8), (i + 1) % 8);
         chk($sformatf("ser.wd%0d", i),  longint'(wd8),  (i == 7) ? 1 : 0);
      end
      chk("ser.q", longint'(q8), 64'h00);

      // 4. enable gaps
      cyc(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      chk("gap.q5sh",  longint'(q8),   64'h80);
      chk("gap.cnt5",  longint'(cnt8), 5);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b1);
         chk("gap.frzq",   longint'(q8),   64'h80);
         chk("gap.frzcnt", longint'(cnt8), 5);
         chk("gap.frzwd",  longint'(wd8),  0);
      end
      cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      chk("gap.wd6", longint'(wd8), 0);
      cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      chk("gap.wd7", longint'(wd8), 0);
      cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      chk("gap.wd8",  longint'(wd8),  1);
      chk("gap.cnt8", longint'(cnt8), 0);
      chk("gap.q8",   longint'(q8),   64'h00);
      cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
      chk("gap.wdoff", longint'(wd8), 0);

      // 5. mid-word reset, then mid-word LOAD
      for (int i = 0; i < 5; i++) cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
      chk("mid.cnt5", longint'(cnt8), 5);
      reset = 1'b1;
      cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
      reset = 1'b0;
      chk("mid.rstq",   longint'(q8),   64'h00);
      chk("mid.rstcnt", longint'(cnt8), 0);
      chk("mid.rstwd",  longint'(wd8),  0);
      for (int i = 0; i < 5; i++) cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, MODE_LOAD, 8'h11, 1'b0, 1'b0);
      chk("mid.ldq",   longint'(q8),   64'h11);
      chk("mid.ldcnt", longint'(cnt8), 0);
      chk("mid.ldwd",  longint'(wd8),  0);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
         chk($sformatf("mid.wd%0d", i), longint'(wd8), (i == 7) ? 1 : 0);
      end

      // 6. non-power-of-two wrap on the 5-bit instance
      reset = 1'b1;
      cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      chk("w5.rstq", longint'(q5), 64'h15);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
         chk($sformatf("w5.q%0d", i),   longint'(q5),   longint'(rol5[i]));
         chk($sformatf("w5.cnt%0d", i), longint'(cnt5), (i + 1) % 5);
         chk($sformatf("w5.wd%0d", i),  longint'(wd5),  (i == 4 || i == 9) ? 1 : 0);
      end
      cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
      chk("w5.wdoff", longint'(wd5), 0);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
